mux4_rr_merge: RTL and testbench
================================

MUX4_RR_MERGE -- requirements
Module: mux4_rr_merge

Interface
REQ-001 Parameter W, default 8, is the data width of every channel in bits.
REQ-002 Channel index mapping SHALL be a=0, b=1, c=2, d=3, encoded on 2 bits with bit 1 as MSB. This matches the demux select encoding {sel0,sel1}: a=00, b=01, c=10, d=11.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  4  per-channel request; bit i belongs to channel i.
REQ-006 in_data  input  4*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-007 in_ready  output  4  per-channel accept strobe; combinational.
REQ-008 out_valid  output  1  output register holds a word.
REQ-009 out_ready  input  1  downstream accepts the word.
REQ-010 out_data  output  W  merged data word.
REQ-011 out_sel  output  2  index of the channel that supplied out_data.

Function
REQ-012 load_en SHALL equal (!out_valid || out_ready).
- The output register loads whenever it is empty or its word is being consumed this cycle.
REQ-013 Arbitration SHALL be round-robin over channels with in_valid=1.
- Search starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- The first valid channel found is granted (g).
REQ-014 in_ready[i] SHALL be 1 only when load_en=1, in_valid[i]=1 and i=g.
- At most one in_ready bit is high in any cycle.
- in_ready is 0 for channels with in_valid=0.
REQ-015 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1.
REQ-016 On a transfer from channel g, the next clock edge SHALL perform:
- out_data <= channel g data
- out_sel <= g
- out_valid <= 1
- ptr <= (g+1) mod 4
REQ-017 When load_en=1 and no in_valid bit is set, the next edge SHALL clear out_valid.
- out_data, out_sel and ptr hold their values.
REQ-018 When load_en=0, the output register and ptr SHALL hold all values.
- Holding applies even if in_valid changes; out_data/out_sel stay stable while out_valid=1 and out_ready=0.
REQ-019 Latency SHALL be exactly one cycle from an input transfer to the word appearing on out_valid/out_data.
REQ-020 Throughput SHALL be one word per cycle while out_ready=1 and at least one input is valid.
- This includes back-to-back consumption and reload in the same cycle.
REQ-021 ptr SHALL wrap from 3 to 0; a grant to channel 3 sets ptr to 0.
REQ-022 With all four channels continuously valid and out_ready=1, grant order SHALL be 0,1,2,3,0,... with no channel starved.
REQ-023 A lone valid channel SHALL be granted every eligible cycle regardless of ptr.
REQ-024 No data bit SHALL be altered; out_data is bit-identical to the granted channel's in_data slice.

Reset
REQ-025 While reset=1, the following SHALL hold immediately and asynchronously:
- out_valid=0, out_data=0, out_sel=2'b00, ptr=0.
- in_ready=4'b0000 follows combinationally, since out_valid=0 makes load_en=1 but granting resumes only after reset deasserts.
REQ-026 Reset asserted mid-stream SHALL discard any word held in the output register.
- No transfer is reported on in_ready during reset.
REQ-027 After reset deassertion, the first grant SHALL favour channel 0 when multiple channels are valid.

Structure
REQ-028 A shared package SHALL hold:
- the channel count constant (4)
- the index width constant (2)
- the channel index constants CH_A..CH_D (0..3), which are reused by the demux-side blocks.
REQ-029 One sub-module, rr_arbiter4, SHALL implement the purely combinational rotating-priority picker.
- Inputs: request[3:0] and ptr[1:0].
- Outputs: grant one-hot[3:0], g[1:0], any.
REQ-030 mux4_rr_merge SHALL contain the output register, ptr register and handshake logic, and instantiate rr_arbiter4 once.

Verification
REQ-031 Reset mid-operation.
- Stimulus: reset pulse while out_valid=1.
- Response: out_valid=0, out_data=0, out_sel=0 immediately; in_ready=0 during reset.
REQ-032 Single channel.
- Stimulus: W=8, only channel c valid with data 8'hA5, out_ready=1.
- Response: in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2'b10.
REQ-033 All channels.
- Stimulus: all four valid with data 8'h10,8'h11,8'h12,8'h13, out_ready=1 for 8 cycles after reset.
- Response: out_sel sequence 0,1,2,3,0,1,2,3; data matches source.
REQ-034 Backpressure.
- Stimulus: out_ready=0 for 3 cycles while a word is held.
- Response: out_data/out_sel unchanged, in_ready=0; the word and next grant appear when out_ready returns to 1.
REQ-035 Wrap-around.
- Stimulus: channel d then channel a and channel d both valid.
- Response: grant d, then a (ptr wrapped to 0), then d.
REQ-036 Drain.
- Stimulus: in_valid=0 with out_ready=1.
- Response: out_valid drops the next cycle; out_data holds its last value.

Source files
------------

// File: rtl/mux4_rr_merge_pkg.sv
// Shared constants for the 4-channel merge/demux family.
package mux4_rr_merge_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 2;

  // Channel indices; encoding matches the demux select {sel0,sel1}.
  localparam logic [IDX_W-1:0] CH_A = 2'd0;
  localparam logic [IDX_W-1:0] CH_B = 2'd1;
  localparam logic [IDX_W-1:0] CH_C = 2'd2;
  localparam logic [IDX_W-1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux4_rr_merge_rr_arbiter4.sv
// Combinational rotating-priority picker: the search starts at ptr and wraps mod 4.
module rr_arbiter4
  import mux4_rr_merge_pkg::*;
(
  input  logic [NUM_CH-1:0] request,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  g,
  output logic              any
);

  logic [IDX_W-1:0] w_idx;

  // First requester found walking ptr, ptr+1, ptr+2, ptr+3 wins.
  always_comb begin
    grant = '0;
    g     = ptr;
    any   = 1'b0;
    w_idx = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = ptr + IDX_W'(k);
      if (!any && request[w_idx]) begin
        any = 1'b1;
        g   = w_idx;
      end
    end
    if (any) grant[g] = 1'b1;
  end

endmodule

// File: rtl/mux4_rr_merge.sv
// Four-channel round-robin merge into a single registered output stage.
module mux4_rr_merge
  import mux4_rr_merge_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   in_valid,
  input  logic [NUM_CH*W-1:0] in_data,
  output logic [NUM_CH-1:0]   in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic [IDX_W-1:0]    out_sel
);

  logic                r_valid;
  logic [W-1:0]        r_data;
  logic [IDX_W-1:0]    r_sel;
  logic [IDX_W-1:0]    r_ptr;

  logic                w_load_en;
  logic [NUM_CH-1:0]   w_grant;
  logic [IDX_W-1:0]    w_g;
  logic                w_any;
  logic [W-1:0]        w_data_sel;

  rr_arbiter4 u_arb (
    .request (in_valid),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .g       (w_g),
    .any     (w_any)
  );

  // Register can take a word when empty or being drained this cycle.
  assign w_load_en = !r_valid || out_ready;

  // Accept strobe is suppressed during reset so no transfer is reported then.
  assign in_ready = (w_load_en && !reset) ? w_grant : '0;

  // Select the granted channel's data slice.
  always_comb begin
    w_data_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_g == IDX_W'(i)) w_data_sel = in_data[i*W +: W];
    end
  end

  // Output register and round-robin pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= CH_A;
      r_ptr   <= CH_A;
    end else if (w_load_en) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_data_sel;
        r_sel   <= w_g;
        r_ptr   <= w_g + 2'd1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux4_rr_merge.sv
// Directed self-checking bench for mux4_rr_merge with W=8.
module tb_mux4_rr_merge;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  int n_total;
  int n_bad;

  mux4_rr_merge #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_valid  = 4'hF;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;

    // Power-on reset: outputs cleared, no accept strobes even with requests.
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_sel",   32'(out_sel),   32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);

    // Single channel c with data A5.
    reset    = 1'b0;
    in_valid = 4'b0100;
    in_data  = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
    #1;
    check("single_ready", 32'(in_ready), 32'b0100);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'hA5);
    check("single_sel",   32'(out_sel),   32'd2);

    // Mid-stream asynchronous reset while a word is held.
    in_valid = 4'b0000;
    out_ready = 1'b0;
    #1;
    check("pre_midrst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    in_valid = 4'b0110;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data",  32'(out_data),  32'd0);
    check("midrst_sel",   32'(out_sel),   32'd0);
    check("midrst_ready", 32'(in_ready),  32'd0);
    step();
    check("midrst_ready2", 32'(in_ready), 32'd0);

    // All four channels valid: strict 0,1,2,3 rotation from reset.
    reset     = 1'b0;
    in_valid  = 4'hF;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("all_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
      step();
      check("all_valid", 32'(out_valid), 32'd1);
      check("all_sel",   32'(out_sel),   32'(i % 4));
      check("all_data",  32'(out_data),  32'(16 + (i % 4)));
    end

    // Backpressure: word 13/sel 3 held for 3 cycles, no grants.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'h13);
      check("bp_sel",   32'(out_sel),   32'd3);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0001);
    step();
    check("bp_release_sel",  32'(out_sel),  32'd0);
    check("bp_release_data", 32'(out_data), 32'h10);

    // Wrap-around: d alone, then a and d together.
    in_valid = 4'b1000;
    #1;
    check("wrap_d_ready", 32'(in_ready), 32'b1000);
    step();
    check("wrap_d_sel", 32'(out_sel), 32'd3);
    in_valid = 4'b1001;
    #1;
    check("wrap_a_ready", 32'(in_ready), 32'b0001);
    step();
    check("wrap_a_sel",  32'(out_sel),  32'd0);
    check("wrap_a_data", 32'(out_data), 32'h10);
    #1;
    check("wrap_d2_ready", 32'(in_ready), 32'b1000);
    step();
    check("wrap_d2_sel",  32'(out_sel),  32'd3);
    check("wrap_d2_data", 32'(out_data), 32'h13);

    // Drain: no requests, out_valid drops, data held.
    in_valid = 4'b0000;
    #1;
    check("drain_ready", 32'(in_ready), 32'd0);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data",  32'(out_data),  32'h13);
    check("drain_sel",   32'(out_sel),   32'd3);
    step();
    check("drain_valid2", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
